// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the core pipeline.
//   XLEN          - default address/PC width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0), used as the idle instruction
//   fetch_state_t - fetch sequencer states
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Drives the PC and a single-outstanding instruction-memory request port,
// and hands fetched instructions to decode over a valid/ready handshake.
// Taken branches and jumps from execute redirect the PC and raise a
// same-cycle flush; a response still in flight at redirect time is dropped.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   branch, branch_target        taken-branch redirect from execute
//   jump, jump_target            unconditional redirect (wins over branch)
//   imem_req_valid/ready, addr   memory request channel
//   imem_rsp_valid, rsp_data     memory response (single-cycle pulse)
//   if_valid/ready, pc, instr    instruction output to decode
//   flush                        squash younger stages this cycle
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            flush
);

  import core_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic [31:0]     hold_instr;

  logic            redirect;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] redirect_target;
  logic            out_free;

  assign redirect        = branch | jump;
  assign raw_target      = jump ? jump_target : branch_target;
  assign redirect_target = {raw_target[XLEN-1:2], 2'b00};
  assign flush           = redirect & ~rst;

  // The hold register is always empty in REQ, so every issued request has a
  // slot to land in (output or hold). A redirect suppresses the request so the
  // old PC is never fetched alongside the new target.
  assign imem_req_valid = (state == REQ) & ~redirect;
  assign imem_addr      = pc;

  assign out_free = ~if_valid | if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      hold_instr <= NOP_INSTR;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
    end else begin
      if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end

      if (redirect) begin
        pc         <= redirect_target;
        if_valid   <= 1'b0;
        hold_instr <= NOP_INSTR;
        // A response arriving this very cycle is discarded here, so only a
        // still-pending request needs the drop flag.
        if (state == WAIT && !imem_rsp_valid) begin
          drop  <= 1'b1;
          state <= WAIT;
        end else begin
          drop  <= 1'b0;
          state <= REQ;
        end
      end else begin
        unique case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_req_ready) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= REQ;
              end else if (out_free) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
                pc       <= pc + XLEN'(4);
                state    <= REQ;
              end else begin
                hold_instr <= imem_rsp_data;
                state      <= HOLD;
              end
            end
          end
          HOLD: begin
            // pc still addresses the held instruction until it moves out.
            if (if_ready) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= hold_instr;
              pc       <= pc + XLEN'(4);
              state    <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a small latency-configurable
// instruction memory that returns (address ^ 32'hA5A5_0000) as data.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        flush;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // memory model state
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_cnt = 0;
  int unsigned lat = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock: accept at the edge, respond lat edges later, settle.
  task automatic tick();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend           = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr ^ TAG;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        req_valid;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] instr;
  } row_t;

  row_t tbl[7];

  initial begin
    rst = 1'b1; branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b1;

    tbl[0] = '{1'b1, RPC,          1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, RPC,          1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 32'h0000_1004, 1'b1, 32'h0000_1000, 32'hA5A5_1000};
    tbl[3] = '{1'b0, 32'h0000_1004, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_1008, 1'b1, 32'h0000_1004, 32'hA5A5_1004};
    tbl[5] = '{1'b0, 32'h0000_1008, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b1, 32'h0000_100C, 1'b1, 32'h0000_1008, 32'hA5A5_1008};

    // reset values
    tick(); tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_flush", 32'(flush), 32'd0);

    // straight-line fetch, single-cycle memory
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("seq%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].req_valid));
      chk($sformatf("seq%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("seq%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk($sformatf("seq%0d_if_pc", i), if_pc, tbl[i].ipc);
        chk($sformatf("seq%0d_if_instr", i), if_instr, tbl[i].instr);
      end
    end

    // decode stalls for 5 cycles while 0x100C returns -> parked in HOLD
    if_ready = 1'b0;
    tick();
    chk("hold_acc_if_pc", if_pc, 32'h0000_1008);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d_req_valid", i), 32'(imem_req_valid), 32'd0);
      chk($sformatf("hold%0d_if_valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("hold%0d_if_pc", i), if_pc, 32'h0000_1008);
    end
    if_ready = 1'b1;
    tick();
    chk("unhold_if_pc", if_pc, 32'h0000_100C);
    chk("unhold_if_instr", if_instr, 32'hA5A5_100C);
    chk("unhold_req_valid", 32'(imem_req_valid), 32'd1);
    chk("unhold_addr", imem_addr, 32'h0000_1010);

    // branch while a slow request is outstanding: stale response dropped
    lat = 3;
    tick();
    chk("br_wait_if_valid", 32'(if_valid), 32'd0);
    branch = 1'b1; branch_target = 32'h0000_0103;
    #1;
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_req_gated", 32'(imem_req_valid), 32'd0);
    tick();
    branch = 1'b0;
    #1;
    chk("br_flush_end", 32'(flush), 32'd0);
    chk("br_drop_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    chk("br_stale_rsp", 32'(imem_rsp_valid), 32'd1);
    tick();
    chk("br_stale_if_valid", 32'(if_valid), 32'd0);
    chk("br_req_valid", 32'(imem_req_valid), 32'd1);
    chk("br_addr", imem_addr, 32'h0000_0100);
    lat = 1;
    tick();
    tick();
    chk("br_if_valid", 32'(if_valid), 32'd1);
    chk("br_if_pc", if_pc, 32'h0000_0100);
    chk("br_if_instr", if_instr, 32'hA5A5_0100);

    // branch + jump coincident with a response: jump wins, response discarded
    tick();
    chk("bj_rsp_arrived", 32'(imem_rsp_valid), 32'd1);
    branch = 1'b1; branch_target = 32'h0000_0200;
    jump = 1'b1;   jump_target   = 32'h0000_0300;
    #1;
    chk("bj_flush", 32'(flush), 32'd1);
    tick();
    branch = 1'b0; jump = 1'b0;
    #1;
    chk("bj_if_valid", 32'(if_valid), 32'd0);
    chk("bj_req_valid", 32'(imem_req_valid), 32'd1);
    chk("bj_addr", imem_addr, 32'h0000_0300);
    tick();
    tick();
    chk("bj_if_pc", if_pc, 32'h0000_0300);
    chk("bj_if_instr", if_instr, 32'hA5A5_0300);

    // jump to top of address space (low bits masked), then PC wraps
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    #1;
    chk("wrap_flush", 32'(flush), 32'd1);
    tick();
    jump = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    tick();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_instr", if_instr, 32'h5A5A_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // reset while waiting on a slow response
    lat = 3;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mrst_addr", imem_addr, RPC);
    chk("mrst_if_valid", 32'(if_valid), 32'd0);
    chk("mrst_if_pc", if_pc, 32'h0);
    chk("mrst_if_instr", if_instr, 32'h0000_0013);
    branch = 1'b1; branch_target = 32'h0000_0040;
    #1;
    chk("mrst_flush_masked", 32'(flush), 32'd0);
    branch = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_stale_rsp", 32'(imem_rsp_valid), 32'd1);
    chk("mrst_restart_req", 32'(imem_req_valid), 32'd1);
    chk("mrst_restart_addr", imem_addr, RPC);
    lat = 1;
    tick();
    chk("mrst_stale_ignored", 32'(if_valid), 32'd0);
    tick();
    chk("mrst_if_valid", 32'(if_valid), 32'd1);
    chk("mrst_if_pc", if_pc, RPC);
    chk("mrst_if_instr", if_instr, 32'hA5A5_1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
